// File: rtl/lbp_hist_pkg.sv
// LBP histogram shared definitions.
// FSM encodings, geometry and border helper.
package lbp_hist_pkg;

  localparam int BIN_W_DEF = 14;
  localparam int NUM_BINS  = 256;
  localparam int IMG_DIM   = 128;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic on_border(input logic [13:0] a);
    logic [6:0] x;
    logic [6:0] y;
    x = a[6:0];
    y = a[13:7];
    return (x == 7'd0) || (x == 7'(IMG_DIM - 1)) ||
           (y == 7'd0) || (y == 7'(IMG_DIM - 1));
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Bin storage: 256 x W, one sync read, one write.
// Read during write to the same bin returns old data.
module hist_ram
  import lbp_hist_pkg::*;
#(
  parameter int W = BIN_W_DEF
) (
  input  logic         clk,
  input  logic         rd_en,
  input  logic [7:0]   rd_addr,
  output logic [W-1:0] rd_data,
  input  logic         wr_en,
  input  logic [7:0]   wr_addr,
  input  logic [W-1:0] wr_data
);

  logic [W-1:0] mem [NUM_BINS];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: clear, accumulate, dump.
// Two-stage read-modify-write with same-bin forwarding.
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_ready,
  output logic [7:0]       hist_addr,
  output logic [BIN_W-1:0] hist_data,
  output logic             hist_valid,
  output logic             hist_done,
  output logic             drop_err
);

  localparam logic [BIN_W-1:0] MAX = '1;

  state_t           state;
  logic [7:0]       cnt;
  logic             p1_valid;
  logic [7:0]       p1_bin;
  logic             w_valid;
  logic [7:0]       w_bin;
  logic [BIN_W-1:0] w_val;
  logic [BIN_W-1:0] rd_data;
  logic [BIN_W-1:0] base;
  logic [BIN_W-1:0] inc;
  logic             accept;
  logic             dump_rd;
  logic [7:0]       dump_addr;
  logic             rd_en;
  logic [7:0]       rd_addr;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [BIN_W-1:0] wr_data;

  assign accept = lbp_valid && (state == S_ACCUM);

  // bin 0 is prefetched in the last drain cycle
  assign dump_rd = ((state == S_DRAIN) && (cnt == 8'd1)) ||
                   ((state == S_DUMP) && (cnt != 8'd255));
  assign dump_addr = (state == S_DUMP) ? cnt + 8'd1 : 8'd0;

  assign rd_en   = accept || dump_rd;
  assign rd_addr = accept ? lbp_data : dump_addr;

  // the previous write is not yet visible to a back-to-back read
  assign base = (w_valid && (w_bin == p1_bin)) ? w_val : rd_data;
  assign inc  = (base == MAX) ? base : base + 1'b1;

  assign wr_en   = (state == S_CLEAR) || p1_valid;
  assign wr_addr = (state == S_CLEAR) ? cnt : p1_bin;
  assign wr_data = (state == S_CLEAR) ? '0 : inc;

  assign hist_data = hist_valid ? rd_data : '0;

  hist_ram #(.W(BIN_W)) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // increment pipeline and forwarding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_bin   <= 8'd0;
      w_valid  <= 1'b0;
      w_bin    <= 8'd0;
      w_val    <= '0;
    end else begin
      p1_valid <= accept;
      p1_bin   <= lbp_data;
      w_valid  <= p1_valid;
      w_bin    <= p1_bin;
      w_val    <= inc;
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      cnt        <= 8'd0;
      hist_ready <= 1'b0;
      hist_valid <= 1'b0;
      hist_addr  <= 8'd0;
      hist_done  <= 1'b0;
    end else begin
      hist_valid <= dump_rd;
      hist_addr  <= dump_addr;
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd255) begin
            state      <= S_ACCUM;
            hist_ready <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (finish) begin
            state      <= S_DRAIN;
            hist_ready <= 1'b0;
            cnt        <= 8'd0;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd1) begin
            state <= S_DUMP;
            cnt   <= 8'd0;
          end
        end
        S_DUMP: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd255) begin
            state     <= S_DONE;
            hist_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // sticky error for dropped or border samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_err <= 1'b0;
    else if (lbp_valid &&
             ((state != S_ACCUM) || on_border(lbp_addr)))
      drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist.
// Each task drives one scenario and checks inline.
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;
  logic [7:0]  hist_addr;
  logic [13:0] hist_data;
  logic        hist_valid;
  logic        hist_done;
  logic        drop_err;

  int pass_cnt = 0;
  int total = 0;

  int dump [256];
  int n_valid;
  int lat;
  int ord_err;
  bit done_seen;
  bit ready_after;

  always #5 clk = ~clk;

  lbp_hist #(.BIN_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_ready (hist_ready),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .hist_valid (hist_valid),
    .hist_done  (hist_done),
    .drop_err   (drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    lbp_addr  = 14'd0;
    lbp_data  = 8'd0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 300 && !hist_ready; i++)
      tick();
    ok = hist_ready;
  endtask

  task automatic send(input logic [7:0] code,
                      input logic [13:0] addr);
    lbp_valid = 1'b1;
    lbp_data  = code;
    lbp_addr  = addr;
    tick();
    lbp_valid = 1'b0;
  endtask

  // caller raises finish (optionally with a sample) first
  task automatic run_dump();
    for (int i = 0; i < 256; i++)
      dump[i] = 0;
    n_valid = 0;
    ord_err = 0;
    tick();
    lbp_valid   = 1'b0;
    finish      = 1'b0;
    ready_after = hist_ready;
    lat = 1;
    while (!hist_valid && lat < 10) begin
      tick();
      lat++;
    end
    while (hist_valid && n_valid < 300) begin
      if (hist_addr != 8'(n_valid))
        ord_err++;
      dump[hist_addr] = int'(hist_data);
      n_valid++;
      tick();
    end
    done_seen = hist_done;
  endtask

  function automatic int dump_sum();
    int s;
    s = 0;
    for (int i = 0; i < 256; i++)
      s += dump[i];
    return s;
  endfunction

  task automatic test_reset();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    lbp_addr  = 14'd0;
    lbp_data  = 8'd0;
    reset     = 1'b1;
    #3;
    total++;
    if ({hist_ready, hist_valid, hist_done, drop_err} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000",
               {hist_ready, hist_valid, hist_done, drop_err});
    end else pass_cnt++;
    total++;
    if ({hist_addr, hist_data} !== 22'd0) begin
      $display("FAIL reset_data: got %0h want 0",
               {hist_addr, hist_data});
    end else pass_cnt++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 255; i++)
      tick();
    total++;
    if (hist_ready !== 1'b0) begin
      $display("FAIL ready_early: got %b want 0", hist_ready);
    end else pass_cnt++;
    tick();
    total++;
    if (hist_ready !== 1'b1) begin
      $display("FAIL ready_257: got %b want 1", hist_ready);
    end else pass_cnt++;
    total++;
    if (drop_err !== 1'b0) begin
      $display("FAIL reset_drop: got %b want 0", drop_err);
    end else pass_cnt++;
  endtask

  // 126x126 interior pixels, all code 0
  task automatic test_bulk();
    for (int y = 1; y <= 126; y++)
      for (int x = 1; x <= 126; x++)
        send(8'h00, {7'(y), 7'(x)});
    finish = 1'b1;
    run_dump();
    total++;
    if (ready_after !== 1'b0) begin
      $display("FAIL bulk_ready_drop: got %b want 0", ready_after);
    end else pass_cnt++;
    total++;
    if (dump[0] != 15876) begin
      $display("FAIL bulk_bin0: got %0d want 15876", dump[0]);
    end else pass_cnt++;
    total++;
    if (dump_sum() - dump[0] != 0) begin
      $display("FAIL bulk_others: got %0d want 0",
               dump_sum() - dump[0]);
    end else pass_cnt++;
    total++;
    if (n_valid != 256 || ord_err != 0) begin
      $display("FAIL bulk_dump_len: got %0d/%0d want 256/0",
               n_valid, ord_err);
    end else pass_cnt++;
    total++;
    if (done_seen !== 1'b1) begin
      $display("FAIL bulk_done: got %b want 1", done_seen);
    end else pass_cnt++;
    total++;
    if (drop_err !== 1'b0) begin
      $display("FAIL bulk_drop: got %b want 0", drop_err);
    end else pass_cnt++;
    repeat (5) tick();
    total++;
    if (hist_done !== 1'b1 || hist_valid !== 1'b0) begin
      $display("FAIL done_sticky: got %b%b want 10",
               hist_done, hist_valid);
    end else pass_cnt++;
    send(8'h10, {7'd5, 7'd5});
    total++;
    if (drop_err !== 1'b1) begin
      $display("FAIL drop_in_done: got %b want 1", drop_err);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    wait_ready(ok);
    total++;
    if (!ok) begin
      $display("FAIL b2b_ready_timeout: got 0 want 1");
    end else pass_cnt++;
    send(8'h5A, {7'd2, 7'd2});
    send(8'h5A, {7'd2, 7'd3});
    send(8'h5A, {7'd2, 7'd4});
    send(8'h13, {7'd2, 7'd5});
    finish = 1'b1;
    run_dump();
    total++;
    if (dump[8'h5A] != 3) begin
      $display("FAIL b2b_bin5a: got %0d want 3", dump[8'h5A]);
    end else pass_cnt++;
    total++;
    if (dump[8'h13] != 1) begin
      $display("FAIL b2b_bin13: got %0d want 1", dump[8'h13]);
    end else pass_cnt++;
    total++;
    if (dump_sum() != 4) begin
      $display("FAIL b2b_sum: got %0d want 4", dump_sum());
    end else pass_cnt++;
  endtask

  task automatic test_saturate();
    bit ok;
    do_reset();
    wait_ready(ok);
    for (int i = 0; i < 16390; i++)
      send(8'h07, {7'd3, 7'd3});
    finish = 1'b1;
    run_dump();
    total++;
    if (dump[7] != 16383) begin
      $display("FAIL sat_bin7: got %0d want 16383", dump[7]);
    end else pass_cnt++;
  endtask

  task automatic test_drop();
    bit ok;
    do_reset();
    repeat (5) tick();
    send(8'h33, {7'd10, 7'd10});
    total++;
    if (drop_err !== 1'b1) begin
      $display("FAIL drop_clear: got %b want 1", drop_err);
    end else pass_cnt++;
    wait_ready(ok);
    send(8'h44, 14'd0);
    finish = 1'b1;
    run_dump();
    total++;
    if (dump[8'h33] != 0) begin
      $display("FAIL drop_clear_cnt: got %0d want 0", dump[8'h33]);
    end else pass_cnt++;
    total++;
    if (dump[8'h44] != 1 || dump_sum() != 1) begin
      $display("FAIL drop_border_cnt: got %0d/%0d want 1/1",
               dump[8'h44], dump_sum());
    end else pass_cnt++;
  endtask

  task automatic test_border_only();
    bit ok;
    do_reset();
    wait_ready(ok);
    send(8'h45, {7'd126, 7'd1});
    total++;
    if (drop_err !== 1'b0) begin
      $display("FAIL interior_drop: got %b want 0", drop_err);
    end else pass_cnt++;
    send(8'h45, {7'd60, 7'd127});
    total++;
    if (drop_err !== 1'b1) begin
      $display("FAIL border_x127: got %b want 1", drop_err);
    end else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit hit;
    do_reset();
    wait_ready(ok);
    for (int i = 0; i < 5; i++)
      send(8'h20, {7'd4, 7'(i + 1)});
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int i = 0; i < 300 && !(hist_valid && hist_addr == 8'd100); i++)
      tick();
    hit = hist_valid && (hist_addr == 8'd100);
    total++;
    if (!hit) begin
      $display("FAIL mid_reach100: got %0d want 100", hist_addr);
    end else pass_cnt++;
    reset = 1'b1;
    #1;
    total++;
    if ({hist_valid, hist_done, hist_ready} !== 3'b0 ||
        hist_data !== 14'd0) begin
      $display("FAIL mid_reset_out: got %b/%0d want 000/0",
               {hist_valid, hist_done, hist_ready}, hist_data);
    end else pass_cnt++;
    tick();
    reset = 1'b0;
    wait_ready(ok);
    for (int i = 0; i < 10; i++)
      send(8'hFF, {7'd8, 7'(i + 1)});
    finish = 1'b1;
    run_dump();
    total++;
    if (dump[255] != 10) begin
      $display("FAIL mid_binff: got %0d want 10", dump[255]);
    end else pass_cnt++;
    total++;
    if (dump_sum() != 10) begin
      $display("FAIL mid_sum: got %0d want 10", dump_sum());
    end else pass_cnt++;
  endtask

  task automatic test_finish_same();
    bit ok;
    do_reset();
    wait_ready(ok);
    send(8'h02, {7'd9, 7'd9});
    send(8'h02, {7'd9, 7'd10});
    lbp_valid = 1'b1;
    lbp_data  = 8'h01;
    lbp_addr  = {7'd9, 7'd11};
    finish    = 1'b1;
    run_dump();
    total++;
    if (lat != 3) begin
      $display("FAIL fin_latency: got %0d want 3", lat);
    end else pass_cnt++;
    total++;
    if (dump[1] != 1) begin
      $display("FAIL fin_bin1: got %0d want 1", dump[1]);
    end else pass_cnt++;
    total++;
    if (dump[2] != 2 || dump_sum() != 3) begin
      $display("FAIL fin_bin2: got %0d/%0d want 2/3",
               dump[2], dump_sum());
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bulk();
    test_back_to_back();
    test_saturate();
    test_drop();
    test_border_only();
    test_mid_reset();
    test_finish_same();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have parameter BIN_W, default 14, meaning bin-counter width (holds 126*126 = 15876).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port lbp_valid, input, 1, one LBP code present this cycle.
REQ-005 SHALL have port lbp_addr, input, 14, pixel address {y[6:0],x[6:0]}, range check only.
REQ-006 SHALL have port lbp_data, input, 8, LBP code = bin index.
REQ-007 SHALL have port finish, input, 1, upstream done; level, sampled each cycle.
REQ-008 SHALL have port hist_ready, output, 1, high only in ACCUM; upstream holds gray_ready low until set.
REQ-009 SHALL have port hist_addr, output, 8, bin index of dumped word.
REQ-010 SHALL have port hist_data, output, BIN_W, bin count of dumped word.
REQ-011 SHALL have port hist_valid, output, 1, hist_addr/hist_data valid this cycle.
REQ-012 SHALL have port hist_done, output, 1, dump complete; sticky until reset.
REQ-013 SHALL have port drop_err, output, 1, sticky; lbp_valid seen outside ACCUM, or lbp_addr on image border (x or y = 0 or 127).

Function
REQ-014 SHALL implement FSM CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE.
REQ-015 CLEAR SHALL write 0 to bins 0..255, one per cycle (256 cycles), then enter ACCUM.
REQ-016 ACCUM SHALL increment bin[lbp_data] by 1 for every cycle lbp_valid=1, back-to-back accepted, no stall.
REQ-017 Increment SHALL be a 2-stage read-modify-write (read, then add+write); same-bin hits on consecutive cycles SHALL forward the in-flight value so no count is lost.
REQ-018 Bin count SHALL saturate at 2^BIN_W-1, never wrap.
REQ-019 Border-address samples SHALL still be counted and SHALL set drop_err.
REQ-020 lbp_valid outside ACCUM SHALL be ignored and SHALL set drop_err.
REQ-021 finish=1 in ACCUM SHALL enter DRAIN; lbp_valid in the same cycle SHALL still be counted.
REQ-022 DRAIN SHALL last exactly 2 cycles, retiring pipeline writes, then enter DUMP.
REQ-023 DUMP SHALL read bins 0..255 in order; hist_valid high 256 consecutive cycles, hist_addr = bin, hist_data = count, 1-cycle read latency.
REQ-024 After bin 255, FSM SHALL enter DONE with hist_done=1 the next cycle; DONE is terminal until reset.
REQ-025 Sum of all dumped hist_data SHALL equal the number of accepted samples (absent saturation).

Reset
REQ-026 Reset SHALL force FSM to CLEAR, clear counter to 0, and zero hist_ready, hist_addr, hist_data, hist_valid, hist_done, drop_err, and pipeline valid bits.
REQ-027 Reset mid-operation SHALL abandon accumulation/dump; bins are cleared by the following CLEAR pass, not by reset.

Structure
REQ-028 Shared package SHALL hold FSM state encodings, BIN_W, NUM_BINS = 256, IMG_DIM = 128.
REQ-029 Bin storage SHALL be sub-module hist_ram: 256 x BIN_W, 1 sync-read port, 1 write port, read-during-write returns old data.

Verification
REQ-030 Reset, wait 256 cycles -> hist_ready rises on cycle 257; drop_err=0.
REQ-031 Feed 15876 valid codes all = 0x00, then finish -> dump shows bin0 = 15876 and all other bins = 0; hist_done after 256 hist_valid cycles.
REQ-032 Back-to-back codes 0x5A, 0x5A, 0x5A, 0x13 -> bin 0x5A = 3 and bin 0x13 = 1 (forwarding check).
REQ-033 Send lbp_valid during CLEAR, and one sample with lbp_addr = 14'd0 in ACCUM -> drop_err = 1; the CLEAR sample is not counted, the border sample is counted.
REQ-034 Assert reset at dump bin 100, then replay 10 codes of 0xFF -> second dump shows bin 0xFF = 10, all others 0.
REQ-035 Drive finish together with the final lbp_valid (code 0x01) -> that sample is counted; dump starts exactly 3 cycles later.
